// File: rtl/rs_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared types and constants for the RS(255,239) encoder over
//                GF(2^8) with primitive polynomial 0x11D. The generator
//                polynomial coefficients are derived at elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int         GF_W       = 8;
    localparam logic [8:0] PRIM_POLY  = 9'h11D;
    localparam int         PARITY_LEN = 16;

    typedef logic [GF_W-1:0] gf_sym_t;

    typedef enum logic [0:0] {
        MSG    = 1'b0,
        PARITY = 1'b1
    } state_t;

    // Multiply by alpha (x) and reduce modulo the primitive polynomial.
    function automatic gf_sym_t gf_xtime(input gf_sym_t a);
        return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? PRIM_POLY[GF_W-1:0] : '0);
    endfunction

    // General GF(2^8) multiply; only ever evaluated on constants here.
    function automatic gf_sym_t gf_mul(input gf_sym_t a, input gf_sym_t b);
        gf_sym_t acc;
        gf_sym_t m;
        acc = '0;
        m   = a;
        for (int k = 0; k < GF_W; k++) begin
            if (b[k]) acc = acc ^ m;
            m = gf_xtime(m);
        end
        return acc;
    endfunction

    // g(x) = prod_{i=0..15} (x + alpha^i), returned low-order coefficient
    // first (g0 in bits [7:0]); the monic g16 term is implicit.
    function automatic logic [PARITY_LEN*GF_W-1:0] gf_gen_poly();
        gf_sym_t g [0:PARITY_LEN];
        gf_sym_t root;
        logic [PARITY_LEN*GF_W-1:0] flat;
        for (int k = 0; k <= PARITY_LEN; k++) g[k] = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < PARITY_LEN; i++) begin
            for (int j = PARITY_LEN; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_xtime(root);
        end
        flat = '0;
        for (int k = 0; k < PARITY_LEN; k++) flat[k*GF_W +: GF_W] = g[k];
        return flat;
    endfunction

    localparam logic [PARITY_LEN*GF_W-1:0] GEN_FLAT = gf_gen_poly();

    localparam gf_sym_t GEN_COEF [0:PARITY_LEN-1] = '{
        GEN_FLAT[  0 +: 8], GEN_FLAT[  8 +: 8], GEN_FLAT[ 16 +: 8], GEN_FLAT[ 24 +: 8],
        GEN_FLAT[ 32 +: 8], GEN_FLAT[ 40 +: 8], GEN_FLAT[ 48 +: 8], GEN_FLAT[ 56 +: 8],
        GEN_FLAT[ 64 +: 8], GEN_FLAT[ 72 +: 8], GEN_FLAT[ 80 +: 8], GEN_FLAT[ 88 +: 8],
        GEN_FLAT[ 96 +: 8], GEN_FLAT[104 +: 8], GEN_FLAT[112 +: 8], GEN_FLAT[120 +: 8]
    };

endpackage
`default_nettype wire

// File: rtl/rs_encoder_gf_poly_const_mul.sv
`default_nettype none
// ============================================================================
//  Module      : gf_poly_const_mul
//  Description : Multiply a GF(2^8) symbol by a fixed constant (polynomial
//                basis, modulo 0x11D). Collapses to an XOR network.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_poly_const_mul
    import rs_pkg::*;
#(
    parameter gf_sym_t CONST = 8'h01
) (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    gf_sym_t w_m;

    // Sum CONST*x^k for every set bit k of the input.
    always_comb begin
        o_y = '0;
        w_m = CONST;
        for (int k = 0; k < GF_W; k++) begin
            if (i_a[k]) o_y = o_y ^ w_m;
            w_m = gf_xtime(w_m);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rs_encoder
//  Description : Systematic RS encoder, GF(2^8)/0x11D, 16 parity symbols.
//                Message symbols pass through with one cycle of latency and
//                are followed by 16 parity symbols. valid/ready on both sides.
//                Optional macro RS_ENC_STATS_EN adds the cw_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_encoder
    import rs_pkg::*;
#(
    parameter int MSG_LEN = 239
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_is_parity
`ifdef RS_ENC_STATS_EN
    ,
    output logic [15:0] cw_count
`endif
);

    localparam logic [7:0] C_LAST_MSG = 8'(MSG_LEN - 1);
    localparam logic [3:0] C_LAST_PAR = 4'(PARITY_LEN - 1);

    state_t     r_state;
    logic [7:0] r_msg_cnt;
    logic [3:0] r_par_cnt;
    gf_sym_t    r_par [0:PARITY_LEN-1];

    logic       r_out_valid;
    gf_sym_t    r_out_data;
    logic       r_out_sop;
    logic       r_out_eop;
    logic       r_out_is_parity;

    logic       w_adv;
    gf_sym_t    w_fb;
    gf_sym_t    w_prod [0:PARITY_LEN-1];

    // The output register may load whenever it is empty or being drained.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = (r_state == MSG) && w_adv;
    assign w_fb     = in_data ^ r_par[PARITY_LEN-1];

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_sop       = r_out_sop;
    assign out_eop       = r_out_eop;
    assign out_is_parity = r_out_is_parity;

    for (genvar gi = 0; gi < PARITY_LEN; gi++) begin : g_mul
        gf_poly_const_mul #(
            .CONST (GEN_COEF[gi])
        ) u_mul (
            .i_a (w_fb),
            .o_y (w_prod[gi])
        );
    end

    // Encoder FSM: LFSR division during MSG, parity shift-out during PARITY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= MSG;
            r_msg_cnt       <= '0;
            r_par_cnt       <= '0;
            for (int i = 0; i < PARITY_LEN; i++) r_par[i] <= '0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_sop       <= 1'b0;
            r_out_eop       <= 1'b0;
            r_out_is_parity <= 1'b0;
        end else if (w_adv) begin
            case (r_state)
                MSG: begin
                    if (in_valid) begin
                        r_par[0] <= w_prod[0];
                        for (int i = 1; i < PARITY_LEN; i++) r_par[i] <= r_par[i-1] ^ w_prod[i];
                        r_out_valid     <= 1'b1;
                        r_out_data      <= in_data;
                        r_out_sop       <= (r_msg_cnt == 8'd0);
                        r_out_eop       <= 1'b0;
                        r_out_is_parity <= 1'b0;
                        if (r_msg_cnt == C_LAST_MSG) begin
                            r_msg_cnt <= '0;
                            r_state   <= PARITY;
                        end else begin
                            r_msg_cnt <= r_msg_cnt + 8'd1;
                        end
                    end else begin
                        // Bubble: nothing to present this cycle.
                        r_out_valid <= 1'b0;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= 1'b0;
                    end
                end
                PARITY: begin
                    r_out_valid     <= 1'b1;
                    r_out_data      <= r_par[PARITY_LEN-1];
                    r_out_sop       <= 1'b0;
                    r_out_eop       <= (r_par_cnt == C_LAST_PAR);
                    r_out_is_parity <= 1'b1;
                    r_par[0]        <= '0;
                    for (int i = 1; i < PARITY_LEN; i++) r_par[i] <= r_par[i-1];
                    // Shifting in zeros leaves the register clear for the next codeword.
                    if (r_par_cnt == C_LAST_PAR) begin
                        r_par_cnt <= '0;
                        r_state   <= MSG;
                    end else begin
                        r_par_cnt <= r_par_cnt + 4'd1;
                    end
                end
                default: r_state <= MSG;
            endcase
        end
    end

`ifdef RS_ENC_STATS_EN
    logic [15:0] r_cw_count;

    assign cw_count = r_cw_count;

    // Count codewords whose final parity symbol has been handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cw_count <= '0;
        end else if (r_out_valid && out_ready && r_out_eop) begin
            r_cw_count <= r_cw_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rs_encoder
//  Description : Self-checking bench for rs_encoder (MSG_LEN 239 and 1),
//                scored against a log/antilog long-division reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_encoder;

    localparam int K0 = 239;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic       out_sop, out_eop, out_par;
    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0] in_data1, out_data1;
    logic       out_sop1, out_eop1, out_par1;
`ifdef RS_ENC_STATS_EN
    logic [15:0] cw_count0, cw_count1;
`endif

    rs_encoder #(.MSG_LEN(K0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_is_parity(out_par)
`ifdef RS_ENC_STATS_EN
        , .cw_count(cw_count0)
`endif
    );

    rs_encoder #(.MSG_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_sop(out_sop1), .out_eop(out_eop1), .out_is_parity(out_par1)
`ifdef RS_ENC_STATS_EN
        , .cw_count(cw_count1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: log/antilog GF arithmetic ----------
    int         gf_exp [0:254];
    int         gf_log [0:255];
    logic [7:0] gen    [0:16];
    logic [7:0] msgbuf [0:K0-1];
    logic [7:0] work   [0:K0+15];
    logic [7:0] cw_ref [0:K0+15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return 8'(gf_exp[(gf_log[a] + gf_log[b]) % 255]);
    endfunction

    task automatic build_tables();
        int e;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            gf_exp[i] = e;
            gf_log[e] = i;
            e = e * 2;
            if (e > 255) e = e ^ 32'h11D;
        end
        for (int j = 0; j <= 16; j++) gen[j] = 8'd0;
        gen[0] = 8'd1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j > 0; j--) gen[j] = gen[j-1] ^ gmul(gen[j], 8'(gf_exp[i]));
            gen[0] = gmul(gen[0], 8'(gf_exp[i]));
        end
    endtask

    // Systematic codeword by polynomial long division of m(x)*x^16 by g(x).
    task automatic model_encode(input int k);
        logic [7:0] c;
        for (int i = 0; i < k + 16; i++) work[i] = (i < k) ? msgbuf[i] : 8'd0;
        for (int i = 0; i < k; i++) begin
            c = work[i];
            for (int j = 1; j <= 16; j++) work[i+j] = work[i+j] ^ gmul(gen[16-j], c);
        end
        for (int i = 0; i < k + 16; i++) cw_ref[i] = (i < k) ? msgbuf[i] : work[i];
    endtask

    // Expected entry layout: {data[7:0], sop, eop, is_parity}
    logic [10:0] exp_q [$];

    task automatic push_cw(input int k);
        model_encode(k);
        for (int i = 0; i < k + 16; i++)
            exp_q.push_back({cw_ref[i], i == 0, i == k + 15, i >= k});
    endtask

    // ---------------- output monitor / scoreboard --------------------------
    logic        prev_stall = 1'b0;
    logic [10:0] prev_sym   = '0;
    logic [10:0] cur;
    logic [7:0]  obs [0:K0+15];
    int          idx        = 0;
    int          par_seen   = 0;
    logic        cnt_en     = 1'b0;
    int          ready_low  = 0;
    logic        rnd_ready  = 1'b0;

    always @(negedge clk) begin
        logic [7:0] s, syn;
        if (!rst_n) begin
            prev_stall = 1'b0;
            idx        = 0;
            par_seen   = 0;
        end else begin
            cur = {out_data, out_sop, out_eop, out_par};
            if (prev_stall) check("stall_hold", 32'({out_valid, cur}), 32'({1'b1, prev_sym}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_symbol", 32'(cur), 32'h7FF);
                else check("out_symbol", 32'(cur), 32'(exp_q.pop_front()));
                if (out_sop) begin
                    idx      = 0;
                    par_seen = 0;
                end
                obs[idx] = out_data;
                if (out_par) par_seen++;
                if (out_eop) begin
                    syn = 8'd0;
                    for (int j = 0; j < 16; j++) begin
                        s = 8'd0;
                        for (int i = 0; i <= idx; i++) s = gmul(s, 8'(gf_exp[j])) ^ obs[i];
                        syn = syn | s;
                    end
                    check("syndrome_or", 32'(syn), 32'd0);
                end
                if (idx < K0 + 15) idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sym   = cur;
            if (cnt_en && !in_ready) ready_low++;
        end
    end

    // Downstream ready: always 1, or a fair coin per cycle when enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic drive_sym(input logic [7:0] d);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_data  = d;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 2000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_msg(input int n, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_sym(msgbuf[i]);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < K0; i++) msgbuf[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, 32'({out_valid, out_sop, out_eop, out_par, out_data}), 32'd0);
    endtask

    // Hard stop if anything wedges.
    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------------------------------
    initial begin
        logic [10:0] c1 [0:16];
        int          got, guard;

        build_tables();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        in_valid1  = 1'b0;
        in_data1   = 8'd0;
        out_ready1 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check_zero_outputs("post_reset_outputs");

        // All-zero message: all-zero codeword with flags at the boundaries.
        for (int i = 0; i < K0; i++) msgbuf[i] = 8'd0;
        push_cw(K0);
        send_msg(K0, 1'b0);
        wait_drain();

        // x^0 message term alone: remainder is the generator tail.
        msgbuf[K0-1] = 8'd1;
        push_cw(K0);
        send_msg(K0, 1'b0);
        wait_drain();
        for (int j = 0; j < 16; j++) check("unit_msg_parity", 32'(obs[K0+j]), 32'(gen[15-j]));

        // 100 random codewords back to back, in_ready low exactly 16 per codeword.
        ready_low = 0;
        cnt_en    = 1'b1;
        for (int c = 0; c < 100; c++) begin
            fill_random();
            push_cw(K0);
            send_msg(K0, 1'b0);
        end
        wait_drain();
        cnt_en = 1'b0;
        check("in_ready_low_cycles", 32'(ready_low), 32'd1600);

        // Random backpressure plus input gaps.
        rnd_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fill_random();
            push_cw(K0);
            send_msg(K0, 1'b1);
        end
        wait_drain();
        rnd_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-message, then a clean codeword.
        fill_random();
        push_cw(K0);
        send_msg(100, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst_mid_msg");
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_random();
        push_cw(K0);
        send_msg(K0, 1'b0);
        wait_drain();

        // Asynchronous reset mid-parity, then a clean codeword.
        fill_random();
        push_cw(K0);
        send_msg(K0, 1'b0);
        guard = 0;
        while (par_seen < 5 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("parity_progress", 32'(par_seen >= 5), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst_mid_parity");
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_random();
        push_cw(K0);
        send_msg(K0, 1'b0);
        wait_drain();

        // Shortest code: one message symbol 0x01 -> 0x01 then g15..g0.
        in_valid1 = 1'b1;
        in_data1  = 8'h01;
        @(negedge clk);
        check("len1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        got   = 0;
        guard = 0;
        while (got < 17 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (out_valid1) begin
                c1[got] = {out_data1, out_sop1, out_eop1, out_par1};
                got++;
            end
        end
        check("len1_count", 32'(got), 32'd17);
        for (int i = 0; i < got; i++)
            check("len1_symbol", 32'(c1[i]),
                  32'({(i == 0) ? 8'h01 : gen[16-i], i == 0, i == 16, i != 0}));
        @(posedge clk);
        #1;
`ifdef RS_ENC_STATS_EN
        check("len1_cw_count", 32'(cw_count1), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
